// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Grants are combinational and the write port is registered, so a write lands one edge later. A busy scoreboard stalls issue on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_waddr,
    input  logic [ADDR_W-1:0]    issue_rs_a,
    input  logic [ADDR_W-1:0]    issue_rs_b,
    output logic                 issue_stall,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_din,
    output logic [2**ADDR_W-1:0] busy
);
    localparam int NREGS = 2**ADDR_W;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    grant_e              last_grant_q, last_grant_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_din_q, rf_din_d;
    logic [NREGS-1:0]    busy_q, busy_d;
    logic [NREGS-1:0]    set_mask, clr_mask;
    logic                wb_fire;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                issue_accept;

    // ALU wins a tie only when MEM was the most recent grant.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (alu_valid && (!mem_valid || last_grant_q == GNT_MEM)) begin
            alu_ready = 1'b1;
        end else if (mem_valid) begin
            mem_ready = 1'b1;
        end
    end

    assign wb_fire = alu_ready | mem_ready;
    assign wb_addr = alu_ready ? alu_addr : mem_addr;
    assign wb_data = alu_ready ? alu_data : mem_data;

    assign issue_stall  = issue_valid &&
                          (busy_q[issue_rs_a] || busy_q[issue_rs_b] || busy_q[issue_waddr]);
    assign issue_accept = issue_valid && !issue_stall;

    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_din_d     = rf_din_q;
        set_mask     = '0;
        clr_mask     = '0;
        if (alu_ready) begin
            last_grant_d = GNT_ALU;
        end else if (mem_ready) begin
            last_grant_d = GNT_MEM;
        end
        if (wb_fire) begin
            rf_we_d    = (wb_addr != '0);
            rf_waddr_d = wb_addr;
            rf_din_d   = wb_data;
        end
        if (issue_accept && issue_waddr != '0) begin
            set_mask[issue_waddr] = 1'b1;
        end
        // Clear on the edge the register file captures the write; set applied last so it wins.
        if (rf_we_q) begin
            clr_mask[rf_waddr_q] = 1'b1;
        end
        busy_d = ((busy_q & ~clr_mask) | set_mask) & {{(NREGS-1){1'b1}}, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_MEM;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_din_q     <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_din_q     <= rf_din_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_din   = rf_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: per-cycle table plus a stall-release sequence.
module tb_regfile_wb_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_waddr = '0;
    logic [AW-1:0] issue_rs_a = '0;
    logic [AW-1:0] issue_rs_b = '0;
    logic          issue_stall;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_din;
    logic [15:0]   busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr),
        .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_din(rf_din), .busy(busy)
    );

    typedef struct {
        int rst; int chk_rdy;
        int iv; int iw; int ra; int rb;
        int av; int aa; int ad;
        int mv; int ma; int md;
        int e_stall; int e_ardy; int e_mrdy;
        int e_we; int e_wa; int e_din; int e_busy;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
    endtask

    initial begin
        int stall_cycles;
        logic done;
        //            rst rdy iv iw ra rb  av aa ad        mv ma md        stl ar mr we wa din      busy
        vecs[0]  = '{1, 0,  0, 0, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 0, 'h0,     'h0};
        vecs[1]  = '{0, 1,  0, 0, 0, 0,  1, 3, 'hBEEF,  0, 0, 'h0,     0,  1, 0, 1, 3, 'hBEEF,  'h0};
        vecs[2]  = '{1, 0,  0, 0, 0, 0,  1, 1, 'h1111,  1, 2, 'h2222,  0,  0, 0, 0, 0, 'h0,     'h0};
        vecs[3]  = '{0, 1,  0, 0, 0, 0,  1, 1, 'h1111,  1, 2, 'h2222,  0,  1, 0, 1, 1, 'h1111,  'h0};
        vecs[4]  = '{0, 1,  0, 0, 0, 0,  1, 1, 'h1112,  1, 2, 'h2222,  0,  0, 1, 1, 2, 'h2222,  'h0};
        vecs[5]  = '{0, 1,  0, 0, 0, 0,  1, 1, 'h1112,  1, 2, 'h2223,  0,  1, 0, 1, 1, 'h1112,  'h0};
        vecs[6]  = '{0, 1,  0, 0, 0, 0,  1, 1, 'h1113,  1, 2, 'h2223,  0,  0, 1, 1, 2, 'h2223,  'h0};
        vecs[7]  = '{0, 1,  0, 0, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 2, 'h2223,  'h0};
        vecs[8]  = '{0, 1,  1, 5, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 2, 'h2223,  'h0020};
        vecs[9]  = '{0, 1,  1, 6, 5, 0,  0, 0, 'h0,     0, 0, 'h0,     1,  0, 0, 0, 2, 'h2223,  'h0020};
        vecs[10] = '{0, 1,  1, 5, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     1,  0, 0, 0, 2, 'h2223,  'h0020};
        vecs[11] = '{0, 1,  1, 0, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 2, 'h2223,  'h0020};
        vecs[12] = '{0, 1,  1, 6, 5, 0,  0, 0, 'h0,     1, 5, 'h5555,  1,  0, 1, 1, 5, 'h5555,  'h0020};
        vecs[13] = '{0, 1,  1, 6, 5, 0,  0, 0, 'h0,     0, 0, 'h0,     1,  0, 0, 0, 5, 'h5555,  'h0};
        vecs[14] = '{0, 1,  1, 6, 5, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 5, 'h5555,  'h0040};
        vecs[15] = '{0, 1,  0, 0, 0, 0,  0, 0, 'h0,     1, 0, 'hFFFF,  0,  0, 1, 0, 0, 'hFFFF,  'h0040};
        vecs[16] = '{0, 1,  0, 0, 0, 0,  1, 9, 'h0909,  0, 0, 'h0,     0,  1, 0, 1, 9, 'h0909,  'h0040};
        vecs[17] = '{0, 1,  1, 9, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 9, 'h0909,  'h0240};
        vecs[18] = '{0, 1,  1, 1, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 9, 'h0909,  'h0242};
        vecs[19] = '{0, 1,  1, 2, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 9, 'h0909,  'h0246};
        vecs[20] = '{0, 1,  1, 4, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 9, 'h0909,  'h0256};
        vecs[21] = '{0, 1,  1, 5, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 9, 'h0909,  'h0276};
        vecs[22] = '{0, 1,  1, 7, 0, 0,  0, 0, 'h0,     0, 0, 'h0,     0,  0, 0, 0, 9, 'h0909,  'h02F6};
        vecs[23] = '{1, 0,  0, 0, 0, 0,  1, 1, 'h1111,  1, 2, 'h2222,  0,  0, 0, 0, 0, 'h0,     'h0};
        vecs[24] = '{0, 1,  0, 0, 0, 0,  1, 1, 'h1111,  1, 2, 'h2222,  0,  1, 0, 1, 1, 'h1111,  'h0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset       = vecs[i].rst[0];
            issue_valid = vecs[i].iv[0];
            issue_waddr = vecs[i].iw[AW-1:0];
            issue_rs_a  = vecs[i].ra[AW-1:0];
            issue_rs_b  = vecs[i].rb[AW-1:0];
            alu_valid   = vecs[i].av[0];
            alu_addr    = vecs[i].aa[AW-1:0];
            alu_data    = vecs[i].ad[DW-1:0];
            mem_valid   = vecs[i].mv[0];
            mem_addr    = vecs[i].ma[AW-1:0];
            mem_data    = vecs[i].md[DW-1:0];
            #1;
            check("issue_stall", i, {31'b0, issue_stall}, vecs[i].e_stall);
            if (vecs[i].chk_rdy != 0) begin
                check("alu_ready", i, {31'b0, alu_ready}, vecs[i].e_ardy);
                check("mem_ready", i, {31'b0, mem_ready}, vecs[i].e_mrdy);
            end
            @(posedge clk);
            #1;
            check("rf_we", i, {31'b0, rf_we}, vecs[i].e_we);
            check("rf_waddr", i, {28'b0, rf_waddr}, vecs[i].e_wa);
            check("rf_din", i, {16'b0, rf_din}, vecs[i].e_din);
            check("busy", i, {16'b0, busy}, vecs[i].e_busy);
        end

        // Reader of r3 must wait for the ALU write to land and the busy bit to drop.
        @(negedge clk);
        reset = 1'b0;
        issue_valid = 1'b1; issue_waddr = 4'd3; issue_rs_a = 4'd0; issue_rs_b = 4'd0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("seq_busy_set", 100, {16'b0, busy}, 32'h0008);

        @(negedge clk);
        issue_waddr = 4'd8; issue_rs_b = 4'd3;
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h3333;
        stall_cycles = 0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            if (!issue_stall) begin
                done = 1'b1;
            end else begin
                stall_cycles++;
                @(negedge clk);
                alu_valid = 1'b0;
            end
        end
        check("seq_stall_released", 101, {31'b0, done}, 32'd1);
        check("seq_stall_cycles", 102, stall_cycles, 32'd2);
        check("seq_rf_din", 103, {16'b0, rf_din}, 32'h3333);
        check("seq_busy_clear", 104, {16'b0, busy}, 32'h0000);
        @(posedge clk);
        #1;
        check("seq_busy_reissue", 105, {16'b0, busy}, 32'h0100);

        @(negedge clk);
        issue_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
